dma_hold_responder: RTL and testbench
=====================================

# dma_hold_responder

Processor-side responder for the DMA controller's HRQ/HLDA bus-hold handshake. It samples HRQ from the DMA priority logic, lets the in-flight CPU bus cycle (and any locked sequence) finish, floats the CPU bus drivers, then asserts HLDA for as long as HRQ stays high. After release it guarantees the CPU a minimum bus tenure before the next grant. It sits between the DMA top level and the CPU bus interface model, and the DMA bench uses it as the HLDA source.

## Interface
- MIN_GAP, default 2: cycles the CPU keeps the bus after a release before HRQ is honoured again (only when cpu_req is high at release); legal range 1..15.
- CLK  in  1  clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- HRQ  in  1  hold request from the DMA controller, active high.
- cpu_cycle_active  in  1  CPU bus cycle in progress; a grant is not allowed while it is high.
- cpu_lock  in  1  CPU locked sequence; a grant is not allowed while it is high.
- cpu_req  in  1  CPU has a pending bus cycle; sampled in RELEASE.
- HLDA  out  1  hold acknowledge to the DMA controller, registered.
- cpu_bus_en  out  1  CPU address/data/control drivers enabled; 0 means floated. Registered.
- hold_active  out  1  high in FLOAT, HOLD and RELEASE.
- hold_cycles  out  16  number of cycles HLDA was high in the current or most recent hold; saturates at 0xFFFF.
- grant_count  out  8  number of HLDA rising edges; wraps from 0xFF to 0x00.

## Operation
- States and outputs:
  - IDLE: CPU owns the bus. cpu_bus_en=1, HLDA=0.
  - DRAIN: HRQ pending, waiting for the CPU cycle or lock to end.
  - FLOAT: one turnaround cycle. cpu_bus_en=0, HLDA=0.
  - HOLD: HLDA=1, cpu_bus_en=0.
  - RELEASE: one turnaround cycle. HLDA=0, cpu_bus_en=0.
  - GAP: CPU tenure. cpu_bus_en=1, HLDA=0, HRQ ignored.
- Transitions:
  - IDLE: if HRQ and grant allowed (cpu_cycle_active=0 and cpu_lock=0), go to FLOAT. If HRQ and blocked, go to DRAIN. Otherwise stay.
  - DRAIN: if HRQ=0, go to IDLE (withdrawn request, no grant). If grant allowed, go to FLOAT. Otherwise stay.
  - FLOAT: if HRQ=1, go to HOLD. If HRQ=0, go to RELEASE (HLDA never asserted).
  - HOLD: stay while HRQ=1. On HRQ=0, go to RELEASE.
  - RELEASE: if cpu_req=1, go to GAP and load the gap counter with MIN_GAP-1. Otherwise go to IDLE.
  - GAP: decrement the counter each cycle. When it reaches 0, go to IDLE.
- cpu_cycle_active and cpu_lock are ignored in FLOAT, HOLD and RELEASE. Upstream must not start CPU cycles while cpu_bus_en=0.
- hold_cycles:
  - Loaded to 1 on the FLOAT→HOLD edge.
  - Incremented each cycle the state stays in HOLD; saturates at 0xFFFF.
  - Otherwise held, so software and the bench can read the last hold length.
- grant_count increments by 1 on each FLOAT→HOLD edge, modulo 256.

## Timing
- Reset values: state IDLE, HLDA=0, cpu_bus_en=1, hold_active=0, hold_cycles=0, grant_count=0, gap counter=0.
- RESET dominates in any state, including mid-hold. HLDA falls and cpu_bus_en rises on the same edge.
- Grant latency: HRQ sampled high at edge N with the grant allowed gives FLOAT after edge N and HLDA=1 after edge N+1 (two cycles).
- A blocked grant adds one cycle per cycle in which cpu_cycle_active or cpu_lock is high.
- Release latency: HRQ sampled low in HOLD at edge M gives HLDA=0 after edge M and cpu_bus_en=1 after edge M+1.
- cpu_bus_en and HLDA are never both 1. There is always at least one cycle with both at 0 between ownership changes.
- HRQ re-asserted in RELEASE or GAP is held off. The earliest HLDA comes MIN_GAP+2 cycles after leaving RELEASE (with cpu_req=1), or 3 cycles after RELEASE (with cpu_req=0).
- A one-cycle HRQ pulse in IDLE produces FLOAT then RELEASE, with no HLDA and no grant_count change.

## Test plan
- Idle grant: reset, then HRQ=1 at cycle 5 with the CPU idle → HLDA=1 from cycle 7. Drop HRQ at cycle 17 → HLDA=0 at cycle 18, cpu_bus_en=1 at cycle 19, hold_cycles=11, grant_count=1.
- Drain: cpu_cycle_active=1 for cycles 4–8, HRQ=1 from cycle 5 → DRAIN, HLDA=1 from cycle 11. Then cpu_lock=1 at cycle 20, HRQ=1 → no HLDA until 2 cycles after lock drops.
- Gap fairness: MIN_GAP=3, cpu_req=1 at release, HRQ re-asserted immediately → HLDA rises exactly 5 cycles after cpu_bus_en returns high, and cpu_bus_en is never 1 together with HLDA.
- Withdrawn requests: HRQ pulsed for one cycle in IDLE, and HRQ dropped while in DRAIN → HLDA stays 0 and grant_count is unchanged.
- Reset mid-hold: RESET=1 for one cycle during HOLD → the next edge gives HLDA=0, cpu_bus_en=1, hold_cycles=0, grant_count=0.
- Counters: hold held for 70000 cycles → hold_cycles=0xFFFF. 257 grants → grant_count=0x01.

Source files
------------

// File: rtl/dma_hold_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dma_hold_responder_if                                    |
// | Description : HRQ/HLDA bus-hold handshake bundle between the DMA       |
// |               controller side and the processor-side hold responder.   |
// | Ports       : HRQ, cpu_cycle_active, cpu_lock, cpu_req  (to responder) |
// |               HLDA, cpu_bus_en, hold_active,                           |
// |               hold_cycles[15:0], grant_count[7:0]  (from responder)    |
// |               slave  modport : responder view                          |
// |               master modport : requester / bench view                  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface dma_hold_responder_if;
  logic        HRQ;
  logic        cpu_cycle_active;
  logic        cpu_lock;
  logic        cpu_req;
  logic        HLDA;
  logic        cpu_bus_en;
  logic        hold_active;
  logic [15:0] hold_cycles;
  logic [7:0]  grant_count;

  modport slave (
    input  HRQ,
    input  cpu_cycle_active,
    input  cpu_lock,
    input  cpu_req,
    output HLDA,
    output cpu_bus_en,
    output hold_active,
    output hold_cycles,
    output grant_count
  );

  modport master (
    output HRQ,
    output cpu_cycle_active,
    output cpu_lock,
    output cpu_req,
    input  HLDA,
    input  cpu_bus_en,
    input  hold_active,
    input  hold_cycles,
    input  grant_count
  );
endinterface
`default_nettype wire

// File: rtl/dma_hold_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dma_hold_responder                                       |
// | Description : Processor-side responder for the HRQ/HLDA bus-hold       |
// |               handshake. Lets the running CPU cycle / locked sequence  |
// |               finish, floats the CPU drivers for one turnaround cycle, |
// |               asserts HLDA while HRQ stays high, then returns the bus  |
// |               with an optional minimum CPU tenure (MIN_GAP).           |
// | Ports       : CLK          clock, rising edge                          |
// |               RESET        synchronous active-high reset               |
// |               hold_bus     slave modport of dma_hold_responder_if      |
// | Parameters  : MIN_GAP      CPU tenure after release, 1..15             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module dma_hold_responder #(
  parameter int MIN_GAP = 2
) (
  input  wire logic              CLK,
  input  wire logic              RESET,
  dma_hold_responder_if.slave    hold_bus
);

  // Reject out-of-range tenure at elaboration; the 4-bit gap counter
  // cannot represent anything beyond 15.
  if ((MIN_GAP < 1) || (MIN_GAP > 15)) begin : g_min_gap_check
    $error("dma_hold_responder: MIN_GAP must be in 1..15");
  end

  localparam logic [3:0] C_GAP_LOAD = 4'(MIN_GAP - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRAIN   = 3'd1;
  localparam logic [2:0] S_FLOAT   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic        hlda_q, hlda_d;
  logic        bus_en_q, bus_en_d;
  logic [15:0] hold_cycles_q, hold_cycles_d;
  logic [7:0]  grant_count_q, grant_count_d;
  logic        w_grant_ok;
  logic        w_grant_edge;

  assign w_grant_ok   = ~hold_bus.cpu_cycle_active & ~hold_bus.cpu_lock;
  assign w_grant_edge = (state_q == S_FLOAT) && (state_d == S_HOLD);

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      gap_q         <= 4'd0;
      hlda_q        <= 1'b0;
      bus_en_q      <= 1'b1;
      hold_cycles_q <= 16'd0;
      grant_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      hlda_q        <= hlda_d;
      bus_en_q      <= bus_en_d;
      hold_cycles_q <= hold_cycles_d;
      grant_count_q <= grant_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (hold_bus.HRQ) begin
          state_d = w_grant_ok ? S_FLOAT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!hold_bus.HRQ) begin
          state_d = S_IDLE;
        end else if (w_grant_ok) begin
          state_d = S_FLOAT;
        end
      end
      S_FLOAT: begin
        state_d = hold_bus.HRQ ? S_HOLD : S_RELEASE;
      end
      S_HOLD: begin
        if (!hold_bus.HRQ) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (hold_bus.cpu_req) begin
          state_d = S_GAP;
          gap_d   = C_GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        // HRQ is deliberately ignored here to guarantee CPU tenure.
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic. HLDA and cpu_bus_en are decoded from the next state so
  // they change on the same edge as the state register; since no state
  // drives both, they can never be high together.
  always_comb begin
    hlda_d        = (state_d == S_HOLD);
    bus_en_d      = (state_d == S_IDLE) || (state_d == S_DRAIN) ||
                    (state_d == S_GAP);
    hold_cycles_d = hold_cycles_q;
    grant_count_d = grant_count_q;
    if (w_grant_edge) begin
      hold_cycles_d = 16'd1;
      grant_count_d = grant_count_q + 8'd1;
    end else if ((state_q == S_HOLD) && (state_d == S_HOLD) &&
                 (hold_cycles_q != 16'hFFFF)) begin
      hold_cycles_d = hold_cycles_q + 16'd1;
    end
  end

  assign hold_bus.HLDA        = hlda_q;
  assign hold_bus.cpu_bus_en  = bus_en_q;
  assign hold_bus.hold_active = (state_q == S_FLOAT) || (state_q == S_HOLD) ||
                                (state_q == S_RELEASE);
  assign hold_bus.hold_cycles = hold_cycles_q;
  assign hold_bus.grant_count = grant_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_hold_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_dma_hold_responder                                    |
// | Description : Directed self-checking bench for dma_hold_responder,     |
// |               instantiated with MIN_GAP=3.                             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_dma_hold_responder;

  logic CLK;
  logic RESET;
  int   errors;
  int   checks;
  logic overlap_seen;
  int   k;

  dma_hold_responder_if bus ();

  dma_hold_responder #(
    .MIN_GAP (3)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .hold_bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // HLDA and cpu_bus_en must never be high together.
  always @(negedge CLK) begin
    if (bus.HLDA && bus.cpu_bus_en) overlap_seen = 1'b1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    overlap_seen = 1'b0;
    RESET        = 1'b1;
    bus.HRQ              = 1'b0;
    bus.cpu_cycle_active = 1'b0;
    bus.cpu_lock         = 1'b0;
    bus.cpu_req          = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    // Reset state
    check("rst_hlda",   32'(bus.HLDA),        32'd0);
    check("rst_bus_en", 32'(bus.cpu_bus_en),  32'd1);
    check("rst_active", 32'(bus.hold_active), 32'd0);
    check("rst_hcyc",   32'(bus.hold_cycles), 32'd0);
    check("rst_gcnt",   32'(bus.grant_count), 32'd0);

    // Idle grant: FLOAT after first edge, HLDA after second
    bus.HRQ = 1'b1;
    tick();
    check("float_hlda",   32'(bus.HLDA),        32'd0);
    check("float_bus_en", 32'(bus.cpu_bus_en),  32'd0);
    check("float_active", 32'(bus.hold_active), 32'd1);
    tick();
    check("grant_hlda",   32'(bus.HLDA),        32'd1);
    check("grant_hcyc",   32'(bus.hold_cycles), 32'd1);
    repeat (10) tick();
    bus.HRQ = 1'b0;
    tick();
    check("rel_hlda",   32'(bus.HLDA),        32'd0);
    check("rel_bus_en", 32'(bus.cpu_bus_en),  32'd0);
    check("rel_active", 32'(bus.hold_active), 32'd1);
    tick();
    check("idle_bus_en", 32'(bus.cpu_bus_en),  32'd1);
    check("idle_hcyc",   32'(bus.hold_cycles), 32'd11);
    check("idle_gcnt",   32'(bus.grant_count), 32'd1);

    // Drain behind an active CPU cycle
    bus.cpu_cycle_active = 1'b1;
    bus.HRQ              = 1'b1;
    tick();
    check("drain_active", 32'(bus.hold_active), 32'd0);
    check("drain_bus_en", 32'(bus.cpu_bus_en),  32'd1);
    tick();
    tick();
    check("drain_hlda", 32'(bus.HLDA), 32'd0);
    bus.cpu_cycle_active = 1'b0;
    tick();
    check("drain_float", 32'(bus.hold_active), 32'd1);
    check("drain_float_hlda", 32'(bus.HLDA), 32'd0);
    tick();
    check("drain_grant", 32'(bus.HLDA),        32'd1);
    check("drain_gcnt",  32'(bus.grant_count), 32'd2);
    bus.HRQ = 1'b0;
    tick();
    tick();

    // Drain behind a locked sequence
    bus.cpu_lock = 1'b1;
    bus.HRQ      = 1'b1;
    repeat (3) tick();
    check("lock_hlda", 32'(bus.HLDA), 32'd0);
    bus.cpu_lock = 1'b0;
    tick();
    check("lock_float_hlda", 32'(bus.HLDA), 32'd0);
    tick();
    check("lock_grant", 32'(bus.HLDA),        32'd1);
    check("lock_gcnt",  32'(bus.grant_count), 32'd3);
    bus.HRQ = 1'b0;
    tick();
    tick();
    check("lock_hcyc", 32'(bus.hold_cycles), 32'd1);

    // One-cycle HRQ pulse in IDLE: FLOAT then RELEASE, no grant
    bus.HRQ = 1'b1;
    tick();
    bus.HRQ = 1'b0;
    tick();
    check("pulse_hlda",   32'(bus.HLDA),        32'd0);
    check("pulse_active", 32'(bus.hold_active), 32'd1);
    tick();
    check("pulse_bus_en", 32'(bus.cpu_bus_en),  32'd1);
    check("pulse_gcnt",   32'(bus.grant_count), 32'd3);
    check("pulse_hcyc",   32'(bus.hold_cycles), 32'd1);

    // HRQ withdrawn while in DRAIN
    bus.cpu_cycle_active = 1'b1;
    bus.HRQ              = 1'b1;
    tick();
    bus.HRQ = 1'b0;
    tick();
    check("wdraw_active", 32'(bus.hold_active), 32'd0);
    bus.cpu_cycle_active = 1'b0;
    tick();
    check("wdraw_hlda", 32'(bus.HLDA),        32'd0);
    check("wdraw_gcnt", 32'(bus.grant_count), 32'd3);

    // Gap fairness with MIN_GAP=3 and cpu_req high at release
    bus.HRQ = 1'b1;
    tick();
    tick();
    check("gap_grant", 32'(bus.HLDA), 32'd1);
    bus.cpu_req = 1'b1;
    bus.HRQ     = 1'b0;
    tick();
    bus.HRQ = 1'b1;
    tick();
    check("gap_bus_en", 32'(bus.cpu_bus_en), 32'd1);
    bus.cpu_req = 1'b0;
    k = 0;
    while ((bus.HLDA !== 1'b1) && (k < 20)) begin
      tick();
      k++;
    end
    check("gap_latency", 32'(k), 32'd5);
    check("gap_gcnt", 32'(bus.grant_count), 32'd5);

    // Reset during HOLD
    tick();
    RESET = 1'b1;
    tick();
    RESET   = 1'b0;
    bus.HRQ = 1'b0;
    check("mrst_hlda",   32'(bus.HLDA),        32'd0);
    check("mrst_bus_en", 32'(bus.cpu_bus_en),  32'd1);
    check("mrst_hcyc",   32'(bus.hold_cycles), 32'd0);
    check("mrst_gcnt",   32'(bus.grant_count), 32'd0);
    check("mrst_active", 32'(bus.hold_active), 32'd0);
    tick();

    // hold_cycles saturation
    bus.HRQ = 1'b1;
    tick();
    tick();
    repeat (70000) tick();
    check("sat_hcyc", 32'(bus.hold_cycles), 32'hFFFF);
    bus.HRQ = 1'b0;
    tick();
    tick();
    check("sat_hcyc_held", 32'(bus.hold_cycles), 32'hFFFF);
    check("sat_gcnt",      32'(bus.grant_count), 32'd1);

    // grant_count wrap: 254 more grants reach 0xFF, then 0x00, then 0x01
    for (int g = 0; g < 256; g++) begin
      bus.HRQ = 1'b1;
      tick();
      tick();
      bus.HRQ = 1'b0;
      tick();
      tick();
      if (g == 253) check("wrap_ff", 32'(bus.grant_count), 32'hFF);
      if (g == 254) check("wrap_00", 32'(bus.grant_count), 32'h00);
    end
    check("wrap_01",    32'(bus.grant_count), 32'h01);
    check("short_hcyc", 32'(bus.hold_cycles), 32'd1);

    check("no_overlap", 32'(overlap_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
